// File: rtl/cpu_fetch.sv
// Instruction fetch stage: issues in-order word reads and queues returned
// instructions with their PCs for decode; flushes on a jump redirect.
module cpu_fetch #(
    parameter logic [31:0] RESET_PC = 32'hFFFF0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] p2_instr,
    output logic [31:0] p2_pc,
    output logic        p2_instr_valid,
    input  logic        p2_bubble,
    input  logic        p4_jump_taken,
    input  logic [31:0] p4_jump_addr
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] ONE     = 1;
    localparam logic [CW-1:0] ZERO    = 0;
    localparam logic [PW-1:0] PONE    = 1;

    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [31:0]    pc_q    [DEPTH];
    logic [31:0]    pc_d    [DEPTH];
    logic [31:0]    instr_q [DEPTH];
    logic [31:0]    instr_d [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [PW-1:0]  head_q, head_d, tail_q, tail_d, fill_q, fill_d;
    logic [CW-1:0]  count_q, count_d, pend_q, pend_d, drop_q, drop_d;

    logic [CW:0] inflight;
    logic        redirect, alloc, fill_hit, drop_hit, rv_owned, pop;

    // Capacity counts responses still owed to flushed requests, so a redirect
    // cannot overrun the queue when the stale data finally arrives.
    assign inflight       = {1'b0, count_q} + {1'b0, drop_q};
    assign redirect       = p4_jump_taken && !stall;
    assign imem_req       = !reset && !redirect && (inflight < DEPTH_C);
    assign imem_addr      = fetch_pc_q;
    assign alloc          = imem_req && imem_ready;
    assign drop_hit       = imem_rvalid && (drop_q != ZERO);
    assign fill_hit       = imem_rvalid && (drop_q == ZERO) && (pend_q != ZERO);
    assign rv_owned       = imem_rvalid && ((drop_q != ZERO) || (pend_q != ZERO));

    assign p2_instr_valid = !reset && filled_q[head_q] && (count_q != ZERO) && !p4_jump_taken;
    assign p2_pc          = reset ? RESET_PC : pc_q[head_q];
    assign p2_instr       = reset ? 32'h0 : instr_q[head_q];
    assign pop            = p2_instr_valid && !stall && !p2_bubble;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        fill_d     = fill_q;
        count_d    = count_q;
        pend_d     = pend_q;
        drop_d     = drop_q;
        filled_d   = filled_q;
        for (int i = 0; i < DEPTH; i++) begin
            pc_d[i]    = pc_q[i];
            instr_d[i] = instr_q[i];
        end
        if (redirect) begin
            // Every request still waiting for data becomes a response to discard.
            fetch_pc_d = p4_jump_addr & 32'hFFFF_FFFC;
            drop_d     = drop_q + pend_q - (rv_owned ? ONE : ZERO);
            head_d     = '0;
            tail_d     = '0;
            fill_d     = '0;
            count_d    = ZERO;
            pend_d     = ZERO;
            filled_d   = '0;
        end else begin
            if (alloc) begin
                pc_d[tail_q]     = fetch_pc_q;
                filled_d[tail_q] = 1'b0;
                tail_d           = tail_q + PONE;
                fetch_pc_d       = fetch_pc_q + 32'd4;
            end
            if (fill_hit) begin
                instr_d[fill_q]  = imem_rdata;
                filled_d[fill_q] = 1'b1;
                fill_d           = fill_q + PONE;
            end
            if (drop_hit) begin
                drop_d = drop_q - ONE;
            end
            if (pop) begin
                filled_d[head_q] = 1'b0;
                head_d           = head_q + PONE;
            end
            count_d = count_q + (alloc ? ONE : ZERO) - (pop ? ONE : ZERO);
            pend_d  = pend_q + (alloc ? ONE : ZERO) - (fill_hit ? ONE : ZERO);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            count_q    <= ZERO;
            pend_q     <= ZERO;
            drop_q     <= ZERO;
            filled_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= RESET_PC;
                instr_q[i] <= 32'h0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fill_q     <= fill_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
            filled_q   <= filled_d;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= pc_d[i];
                instr_q[i] <= instr_d[i];
            end
        end
    end
endmodule

// File: tb/tb_cpu_fetch.sv
// Bench for cpu_fetch: queue-based reference model plus an in-order
// instruction memory with variable latency, directed scenarios then random.
`timescale 1ns/1ps
module tb_cpu_fetch;
    localparam logic [31:0] RESET_PC = 32'hFFFF0000;
    localparam int          DEPTH    = 4;

    logic        clock = 1'b0;
    logic        reset, stall, imem_req, imem_ready, imem_rvalid;
    logic        p2_instr_valid, p2_bubble, p4_jump_taken;
    logic [31:0] imem_addr, imem_rdata, p2_instr, p2_pc, p4_jump_addr;

    cpu_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .p2_instr(p2_instr), .p2_pc(p2_pc), .p2_instr_valid(p2_instr_valid),
        .p2_bubble(p2_bubble), .p4_jump_taken(p4_jump_taken), .p4_jump_addr(p4_jump_addr)
    );

    always #5 clock = ~clock;

    // Stimulus for the next cycle
    logic        n_reset, n_stall, n_bubble, n_jump, n_ready;
    logic [31:0] n_jaddr;
    int          lat_min, lat_max;

    // Reference model: fetch PC, queue of {pc, instr, filled}, discard count
    logic [31:0] m_pc;
    logic [31:0] q_pc[$];
    logic [31:0] q_instr[$];
    bit          q_filled[$];
    int          m_drop;

    // Instruction memory: in-order responses, each with its due cycle
    logic [31:0] mem_data[$];
    int          mem_due[$];
    int          last_due, cyc;

    int vectors, miscompares, checks;

    function automatic logic [31:0] memword(logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        bit          rv, exp_req, exp_valid;
        logic [31:0] rd;
        int          unf, fi, lat, due;
        @(negedge clock);
        reset         = n_reset;
        stall         = n_stall;
        p2_bubble     = n_bubble;
        p4_jump_taken = n_jump;
        p4_jump_addr  = n_jaddr;
        imem_ready    = n_ready;
        rv            = !n_reset && (mem_due.size() > 0) && (mem_due.size() > 0 ? mem_due[0] <= cyc : 1'b0);
        rd            = rv ? mem_data[0] : $urandom;
        imem_rvalid   = rv;
        imem_rdata    = rd;
        #1;
        vectors++;
        unf = 0;
        foreach (q_filled[i]) if (!q_filled[i]) unf++;
        exp_req   = !n_reset && !(n_jump && !n_stall) && (q_pc.size() + m_drop < DEPTH);
        exp_valid = !n_reset && (q_pc.size() > 0) && (q_pc.size() > 0 ? q_filled[0] : 1'b0) && !n_jump;

        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        chk("p2_instr_valid", 32'(p2_instr_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("p2_pc", p2_pc, q_pc[0]);
            chk("p2_instr", p2_instr, q_instr[0]);
        end
        if (n_reset) begin
            chk("reset_p2_pc", p2_pc, RESET_PC);
            chk("reset_p2_instr", p2_instr, 32'h0);
        end
        if (rv && m_drop == 0 && unf == 0) begin
            miscompares++;
            $display("FAIL protocol: rvalid with no outstanding request (cycle %0d)", cyc);
        end

        if (n_reset) begin
            m_pc = RESET_PC;
            q_pc.delete(); q_instr.delete(); q_filled.delete();
            m_drop = 0;
            mem_data.delete(); mem_due.delete();
            last_due = cyc;
        end else if (n_jump && !n_stall) begin
            m_drop = m_drop + unf - ((rv && (m_drop + unf > 0)) ? 1 : 0);
            q_pc.delete(); q_instr.delete(); q_filled.delete();
            m_pc = n_jaddr & 32'hFFFF_FFFC;
        end else begin
            if (rv) begin
                if (m_drop > 0) m_drop--;
                else begin
                    fi = -1;
                    for (int i = 0; i < q_filled.size(); i++)
                        if (!q_filled[i]) begin fi = i; break; end
                    if (fi >= 0) begin
                        q_instr[fi]  = rd;
                        q_filled[fi] = 1'b1;
                    end
                end
            end
            if (exp_valid && !n_stall && !n_bubble) begin
                void'(q_pc.pop_front()); void'(q_instr.pop_front()); void'(q_filled.pop_front());
            end
            if (exp_req && n_ready) begin
                q_pc.push_back(m_pc); q_instr.push_back(32'h0); q_filled.push_back(1'b0);
                lat = $urandom_range(lat_max, lat_min);
                due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                last_due = due;
                mem_data.push_back(memword(m_pc));
                mem_due.push_back(due);
                m_pc = m_pc + 32'd4;
            end
        end
        if (rv) begin
            void'(mem_data.pop_front()); void'(mem_due.pop_front());
        end
        cyc++;
    endtask

    task automatic do_reset();
        n_reset = 1'b1; step();
        n_reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0; miscompares = 0; checks = 0; cyc = 0; last_due = 0;
        m_pc = RESET_PC; m_drop = 0;
        reset = 1'b1; stall = 1'b0; p2_bubble = 1'b0; p4_jump_taken = 1'b0;
        p4_jump_addr = 32'h0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        n_reset = 1'b1; n_stall = 1'b0; n_bubble = 1'b0; n_jump = 1'b0;
        n_jaddr = 32'h0; n_ready = 1'b1; lat_min = 1; lat_max = 1;

        step(); step();
        chk("lit_reset_req", 32'(imem_req), 32'h0);
        chk("lit_reset_valid", 32'(p2_instr_valid), 32'h0);
        chk("lit_reset_pc", p2_pc, 32'hFFFF0000);

        // Streaming after reset, latency 1, always ready
        n_reset = 1'b0;
        step(); chk("lit_addr0", imem_addr, 32'hFFFF0000); chk("lit_req0", 32'(imem_req), 32'h1);
        step(); chk("lit_addr1", imem_addr, 32'hFFFF0004);
        step(); chk("lit_addr2", imem_addr, 32'hFFFF0008);
        chk("lit_pc2", p2_pc, 32'hFFFF0000);
        chk("lit_valid2", 32'(p2_instr_valid), 32'h1);
        chk("lit_instr2", p2_instr, 32'h1357_9BDF ^ 32'h00FF_FF00);

        // Bubble for two cycles holds the head for three
        n_bubble = 1'b1;
        step(); chk("lit_bub_pc0", p2_pc, 32'hFFFF0004);
        step(); chk("lit_bub_pc1", p2_pc, 32'hFFFF0004);
        n_bubble = 1'b0;
        step(); chk("lit_bub_pc2", p2_pc, 32'hFFFF0004);
        chk("lit_full_req", 32'(imem_req), 32'h0);
        step(); chk("lit_resume_pc", p2_pc, 32'hFFFF0008);
        step();

        // Stall until the queue is full, then release
        n_stall = 1'b1;
        repeat (5) step();
        chk("lit_stall_req", 32'(imem_req), 32'h0);
        n_stall = 1'b0;
        repeat (4) step();

        // Redirect with two requests outstanding at latency 3
        do_reset();
        lat_min = 3; lat_max = 3;
        step(); step();
        n_jump = 1'b1; n_jaddr = 32'h0000_1002;
        step(); chk("lit_jump_req", 32'(imem_req), 32'h0);
        n_jump = 1'b0;
        step(); chk("lit_jump_addr", imem_addr, 32'h0000_1000);
        for (int i = 0; i < 20 && !p2_instr_valid; i++) step();
        if (!p2_instr_valid) begin
            miscompares++;
            $display("FAIL jump_wait: no valid instruction within 20 cycles");
        end else chk("lit_jump_pc", p2_pc, 32'h0000_1000);

        // Jump held off by stall, then redirect near the top of memory
        do_reset();
        lat_min = 1; lat_max = 1;
        repeat (4) step();
        n_stall = 1'b1; n_jump = 1'b1; n_jaddr = 32'hFFFF_FFF9;
        step(); chk("lit_jstall_valid", 32'(p2_instr_valid), 32'h0);
        n_stall = 1'b0;
        step(); chk("lit_redirect_req", 32'(imem_req), 32'h0);
        n_jump = 1'b0;
        step(); chk("lit_wrap_a", imem_addr, 32'hFFFF_FFF8);
        step(); chk("lit_wrap_b", imem_addr, 32'hFFFF_FFFC);
        step(); chk("lit_wrap_c", imem_addr, 32'h0000_0000);

        // Reset in the middle of outstanding traffic
        lat_min = 3; lat_max = 3;
        repeat (3) step();
        n_reset = 1'b1;
        step();
        chk("lit_mid_reset_req", 32'(imem_req), 32'h0);
        chk("lit_mid_reset_valid", 32'(p2_instr_valid), 32'h0);
        chk("lit_mid_reset_pc", p2_pc, 32'hFFFF0000);
        n_reset = 1'b0;
        step(); chk("lit_after_reset_addr", imem_addr, 32'hFFFF0000);

        // Randomized traffic
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            n_reset  = ($urandom_range(0, 299) == 0);
            n_stall  = ($urandom_range(0, 4) == 0);
            n_bubble = ($urandom_range(0, 4) == 0);
            n_jump   = ($urandom_range(0, 19) == 0);
            n_jaddr  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            n_ready  = ($urandom_range(0, 3) != 0);
            if (i == 1500) begin lat_min = 1; lat_max = 1; end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
